// File: rtl/soc_reset_pkg.sv
// Shared types for the SoC reset sequencer.
// State encoding and cause-bit positions.
package soc_reset_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN
  } state_e;

  localparam int CAUSE_POR = 0;

endpackage

// File: rtl/soc_reset_seq_if.sv
// Reset-control bundle between the SoC fabric and the sequencer.
// master = request/cause owner, slave = sequencer.
interface soc_reset_seq_if #(
  parameter int NUM_DOM = 2,
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0] RST_REQ;
  logic [NUM_REQ-1:0] REQ_MASK;
  logic               CAUSE_CLR;
  logic [NUM_DOM-1:0] DOM_RESETn;
  logic               RST_ACTIVE;
  logic [NUM_REQ:0]   RST_CAUSE;

  modport master (
    output RST_REQ,
    output REQ_MASK,
    output CAUSE_CLR,
    input  DOM_RESETn,
    input  RST_ACTIVE,
    input  RST_CAUSE
  );

  modport slave (
    input  RST_REQ,
    input  REQ_MASK,
    input  CAUSE_CLR,
    output DOM_RESETn,
    output RST_ACTIVE,
    output RST_CAUSE
  );

endinterface

// File: rtl/soc_reset_seq_sync_bit.sv
// Multi-flop synchroniser for one asynchronous request bit.
// Clears to 0 on power-on reset.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/soc_reset_seq.sv
// Reset sequencer: stretches POR/soft resets and releases
// domains one by one in index order, recording a sticky cause.
module soc_reset_seq
  import soc_reset_pkg::*;
#(
  parameter int NUM_DOM     = 2,
  parameter int NUM_REQ     = 2,
  parameter int CTR_W       = 8,
  parameter int STRETCH     = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic           CLK,
  input  logic           RESET,
  soc_reset_seq_if.slave bus
);

  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam logic [CTR_W-1:0] STR = CTR_W'(STRETCH);

  if (NUM_DOM < 1 || NUM_REQ < 1 || SYNC_STAGES < 2 ||
      STRETCH < 1 || STRETCH >= (1 << CTR_W)) begin : g_bad_cfg
    $error("soc_reset_seq: illegal parameter set");
  end

  logic [NUM_REQ-1:0] req_sync;
  logic [NUM_REQ-1:0] hit_v;
  logic               req_hit;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_sync
    sync_bit #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk_i(CLK),
      .rst_i(RESET),
      .d_i  (bus.RST_REQ[i]),
      .q_o  (req_sync[i])
    );
  end

  assign hit_v   = req_sync & bus.REQ_MASK;
  assign req_hit = |hit_v;

  state_e             state_q, state_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DOM-1:0] dom_q, dom_d;
  logic               act_q, act_d;
  logic [NUM_REQ:0]   cause_q, cause_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= HOLD;
      ctr_q   <= STR;
      idx_q   <= '0;
      dom_q   <= '0;
      act_q   <= 1'b1;
      cause_q <= '0;
      cause_q[CAUSE_POR] <= 1'b1;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      act_q   <= act_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    unique case (state_q)
      HOLD: begin
        dom_d = '0;
        if (req_hit) begin
          ctr_d = STR;
        end else if (ctr_q != '0) begin
          ctr_d = ctr_q - CTR_W'(1);
        end else begin
          dom_d[0] = 1'b1;
          idx_d    = IDX_W'(1);
          ctr_d    = STR;
          state_d  = (NUM_DOM == 1) ? RUN : RELEASE;
        end
      end
      RELEASE: begin
        if (req_hit) begin
          dom_d   = '0;
          ctr_d   = STR;
          idx_d   = '0;
          state_d = HOLD;
        end else if (ctr_q != '0) begin
          ctr_d = ctr_q - CTR_W'(1);
        end else begin
          for (int k = 0; k < NUM_DOM; k++) begin
            if (IDX_W'(k) == idx_q) dom_d[k] = 1'b1;
          end
          ctr_d = STR;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_DOM - 1)) state_d = RUN;
        end
      end
      RUN: begin
        if (req_hit) begin
          dom_d   = '0;
          ctr_d   = STR;
          idx_d   = '0;
          state_d = HOLD;
        end
      end
      default: begin
        dom_d   = '0;
        ctr_d   = STR;
        idx_d   = '0;
        state_d = HOLD;
      end
    endcase
  end

  // A new hit wins over a coincident clear for its own bit
  always_comb begin
    cause_d = bus.CAUSE_CLR ? '0 : cause_q;
    cause_d = cause_d | {hit_v, 1'b0};
  end

  assign act_d = ~&dom_d;

  assign bus.DOM_RESETn = dom_q;
  assign bus.RST_ACTIVE = act_q;
  assign bus.RST_CAUSE  = cause_q;

endmodule

// File: tb/tb_soc_reset_seq.sv
// Randomised bench for soc_reset_seq against a quiet-time model.
// Domain k is up once (k+1)*(STRETCH+1) hit-free edges have passed.
module tb_soc_reset_seq;

  localparam int ND = 2;
  localparam int NR = 2;
  localparam int S  = 3;
  localparam int SS = 2;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  soc_reset_seq_if #(.NUM_DOM(ND), .NUM_REQ(NR)) bus ();

  soc_reset_seq #(
    .NUM_DOM    (ND),
    .NUM_REQ    (NR),
    .CTR_W      (8),
    .STRETCH    (S),
    .SYNC_STAGES(SS)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  bit [NR-1:0] pipe[$];
  int          quiet;
  logic [NR:0] m_cause;

  function automatic void m_reset();
    pipe = {};
    for (int i = 0; i < SS; i++) pipe.push_back('0);
    quiet   = 0;
    m_cause = 1;
  endfunction

  function automatic void m_edge();
    bit [NR-1:0] eff;
    bit [NR-1:0] hv;
    eff = pipe.pop_front();
    pipe.push_back(bus.RST_REQ);
    hv = eff & bus.REQ_MASK;
    if (hv != 0) quiet = 0;
    else if (quiet < 100000) quiet++;
    m_cause = (bus.CAUSE_CLR ? '0 : m_cause) | {hv, 1'b0};
  endfunction

  function automatic logic [ND-1:0] m_dom();
    logic [ND-1:0] d;
    for (int k = 0; k < ND; k++) d[k] = (quiet >= (k + 1) * (S + 1));
    return d;
  endfunction

  task automatic step(input logic [NR-1:0] req, input logic [NR-1:0] mask,
                      input logic clr, input string tag);
    logic [ND-1:0] ed;
    bus.RST_REQ   = req;
    bus.REQ_MASK  = mask;
    bus.CAUSE_CLR = clr;
    @(posedge CLK);
    if (!RESET) m_edge();
    #1;
    ed = m_dom();
    chk({tag, ".dom"}, 32'(bus.DOM_RESETn), 32'(ed));
    chk({tag, ".act"}, 32'(bus.RST_ACTIVE), 32'(~&ed));
    chk({tag, ".cause"}, 32'(bus.RST_CAUSE), 32'(m_cause));
  endtask

  task automatic idle(input int n, input logic [NR-1:0] mask,
                      input string tag);
    for (int i = 0; i < n; i++) step('0, mask, 1'b0, tag);
  endtask

  task automatic async_reset(input string tag);
    #3;
    RESET = 1'b1;
    #1;
    m_reset();
    chk({tag, ".dom"}, 32'(bus.DOM_RESETn), 32'h0);
    chk({tag, ".act"}, 32'(bus.RST_ACTIVE), 32'h1);
    chk({tag, ".cause"}, 32'(bus.RST_CAUSE), 32'h1);
    step('0, 2'b11, 1'b0, {tag, "_hold"});
    step('0, 2'b11, 1'b0, {tag, "_hold"});
    RESET = 1'b0;
  endtask

  initial begin
    bus.RST_REQ   = '0;
    bus.REQ_MASK  = 2'b11;
    bus.CAUSE_CLR = 1'b0;
    m_reset();
    #1;
    chk("por_async.dom", 32'(bus.DOM_RESETn), 32'h0);
    for (int i = 0; i < 5; i++) step('0, 2'b11, 1'b0, "por_hold");
    RESET = 1'b0;
    idle(3, 2'b11, "por_wait");
    step('0, 2'b11, 1'b0, "por_e4");
    chk("por_e4_abs", 32'(bus.DOM_RESETn), 32'h1);
    idle(3, 2'b11, "por_wait");
    step('0, 2'b11, 1'b0, "por_e8");
    chk("por_e8_abs", 32'(bus.DOM_RESETn), 32'h3);
    chk("por_cause_abs", 32'(bus.RST_CAUSE), 32'h1);

    step(2'b01, 2'b11, 1'b0, "soft");
    idle(12, 2'b11, "soft");
    chk("soft_cause_abs", 32'(bus.RST_CAUSE), 32'h3);

    for (int i = 0; i < 20; i++) step(2'b10, 2'b11, 1'b0, "held");
    idle(12, 2'b11, "held");
    chk("held_cause_abs", 32'(bus.RST_CAUSE[2]), 32'h1);

    step(2'b10, 2'b01, 1'b0, "masked");
    idle(6, 2'b01, "masked");
    chk("masked_dom_abs", 32'(bus.DOM_RESETn), 32'h3);

    step(2'b01, 2'b11, 1'b0, "abort");
    idle(4, 2'b11, "abort");
    step(2'b01, 2'b11, 1'b0, "abort_hit");
    step('0, 2'b11, 1'b0, "abort");
    step('0, 2'b11, 1'b0, "abort_drop");
    chk("abort_dom_abs", 32'(bus.DOM_RESETn), 32'h0);
    idle(10, 2'b11, "abort_rel");

    step(2'b01, 2'b11, 1'b0, "clr");
    step('0, 2'b11, 1'b0, "clr");
    step('0, 2'b11, 1'b1, "clr_hit");
    chk("clr_cause_abs", 32'(bus.RST_CAUSE), 32'h2);
    idle(10, 2'b11, "clr");

    async_reset("arst");
    idle(10, 2'b11, "arst_rel");

    begin
      logic [NR-1:0] mask;
      logic [NR-1:0] req;
      mask = 2'b11;
      req  = '0;
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 49) == 0) mask = NR'($urandom);
        if ($urandom_range(0, 9) == 0) req = NR'($urandom);
        else if ($urandom_range(0, 2) == 0) req = '0;
        step(req, mask, ($urandom_range(0, 19) == 0), "rnd");
      end
    end
    idle(10, 2'b11, "rnd_tail");
    async_reset("arst2");
    idle(10, 2'b11, "arst2_rel");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/soc_reset_seq.md
Name: soc_reset_seq

Overview:
Parametrised reset sequencer. It replaces the fixed 4-bit CPU reset stretcher in the SoC top.
- Generates NUM_DOM active-low domain resets (e.g. bus/peripherals, then CPU) with programmable stretch.
- Releases domains in index order.
- Accepts NUM_REQ maskable soft-reset requests (SYSRESETREQ, watchdog, debug), synchronises them, and records a sticky reset cause.

Parameters:
NUM_DOM, 2, number of reset domains; released in ascending index order
NUM_REQ, 2, number of soft-reset request sources
CTR_W, 8, stretch counter width
STRETCH, 15, hold/inter-release interval in cycles; legal range 1..2**CTR_W-1
SYNC_STAGES, 2, synchroniser depth on each RST_REQ bit; minimum 2

Ports:
CLK  in  1  system clock
RESET  in  1  power-on reset; asynchronous, active-high
RST_REQ  in  NUM_REQ  soft-reset requests; level, may be asynchronous to CLK
REQ_MASK  in  NUM_REQ  per-source enable, 1 = honoured; quasi-static
CAUSE_CLR  in  1  single-cycle pulse that clears RST_CAUSE
DOM_RESETn  out  NUM_DOM  per-domain reset, active-low; bit 0 is released first
RST_ACTIVE  out  1  high while any DOM_RESETn bit is low
RST_CAUSE  out  NUM_REQ+1  sticky cause; bit 0 = POR, bit i+1 = RST_REQ[i]

Behaviour:
Reset and output timing
- RESET high, asynchronously: DOM_RESETn = all 0, RST_ACTIVE = 1, RST_CAUSE = {NUM_REQ'b0, 1'b1}, state = HOLD, ctr = STRETCH, idx = 0, synchronisers = 0.
- All outputs are driven from flops. DOM_RESETn assertion is asynchronous only via RESET. Every deassertion is synchronous to CLK.
- RST_ACTIVE = ~&DOM_RESETn.

FSM states: HOLD, RELEASE, RUN.
- req_hit = |(req_sync & REQ_MASK).
- HOLD: all domains low.
  - req_hit: ctr <= STRETCH (stretch is counted from request deassertion).
  - else if ctr != 0: ctr--.
  - else: DOM_RESETn[0] <= 1, idx <= 1, ctr <= STRETCH, go to RELEASE. If NUM_DOM == 1, go to RUN instead.
- RELEASE:
  - req_hit: all DOM_RESETn <= 0, ctr <= STRETCH, idx <= 0, go to HOLD (abort).
  - else if ctr != 0: ctr--.
  - else: DOM_RESETn[idx] <= 1, ctr <= STRETCH, idx++. On the edge that releases idx == NUM_DOM-1, go to RUN.
- RUN:
  - req_hit: all DOM_RESETn <= 0, ctr <= STRETCH, idx <= 0, go to HOLD.

Timing
- Domain k deasserts on edge (k+1)*(STRETCH+1) after the first edge with RESET low and no request.
- Latency from RST_REQ rise to DOM_RESETn low is SYNC_STAGES+1 edges.

Cause register
- On each edge where req_hit is true, RST_CAUSE[i+1] |= req_sync[i] & REQ_MASK[i].
- CAUSE_CLR clears all bits. When CAUSE_CLR coincides with a new set, the set wins for that bit.
- Soft resets never clear RST_CAUSE. The POR bit is set only by RESET.

Other rules
- A masked request has no effect on state or cause.
- A request held high keeps all domains in HOLD indefinitely.
- Elaboration error if NUM_DOM < 1, NUM_REQ < 1, SYNC_STAGES < 2, STRETCH < 1, or STRETCH >= 2**CTR_W.

Decomposition:
- Package soc_reset_pkg:
  - state enum typedef {HOLD, RELEASE, RUN}
  - localparam CAUSE_POR = 0
- Sub-module sync_bit: SYNC_STAGES flop chain, async active-high reset to 0, one instance per RST_REQ bit.

Test Plan:
All scenarios use NUM_DOM=2, NUM_REQ=2, STRETCH=3, SYNC_STAGES=2.
1. POR: RESET high 5 cycles, then low.
   -> DOM_RESETn=2'b00 while RESET high; bit0 high on edge 4, bit1 on edge 8; RST_ACTIVE low from edge 8; RST_CAUSE=3'b001.
2. Soft reset: in RUN with REQ_MASK=2'b11, 1-cycle RST_REQ[0] pulse.
   -> DOM_RESETn=2'b00 on edge 3; bit0 released 4 edges later, bit1 8 edges later; RST_CAUSE=3'b011.
3. Held request: RST_REQ[1] high for 20 cycles.
   -> both domains low throughout; release sequence begins 4 edges after synchronised deassertion; RST_CAUSE[2]=1.
4. Masked source: REQ_MASK=2'b01, pulse RST_REQ[1].
   -> DOM_RESETn stays 2'b11; RST_CAUSE unchanged.
5. Abort mid-sequence: RST_REQ[0] pulse so that the synchronised hit lands after bit0 release but before bit1.
   -> DOM_RESETn returns to 2'b00; full 4/8-edge sequence restarts.
6. Clear and async reset:
   - CAUSE_CLR on the same edge as a RST_REQ[0] hit -> RST_CAUSE=3'b010.
   - RESET asserted mid-RUN between edges -> DOM_RESETn=2'b00 immediately, with no clock edge; RST_CAUSE=3'b001.
